// File: rtl/fir_host_pkg.sv
// -----------------------------------------------------------------------------
// fir_host_pkg
// Shared types and constants for the FIR host sequencer:
//   - state_e       : sequencer states (IDLE, LOAD_ACC, LOAD_HOLD, RUN)
//   - COEF_HOLD     : cycles cload is held high per coefficient write
//   - *_DEF         : default widths/sizes used by the modules and interface
//   - sat_inc16     : saturating 16-bit increment for the sample counter
// -----------------------------------------------------------------------------
package fir_host_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_ACC  = 2'd1,
    LOAD_HOLD = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int COEF_HOLD = 2;

  localparam int NTAPS_DEF       = 64;
  localparam int AW_DEF          = 6;
  localparam int DW_DEF          = 16;
  localparam int OW_DEF          = 32;
  localparam int SAMPLE_DIV_DEF  = 200;
  localparam int RFIFO_DEPTH_DEF = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fir_host_if.sv
// -----------------------------------------------------------------------------
// fir_host_if
// Host-side stream bundle for the FIR sequencer:
//   s_valid/s_ready/s_data : upstream coefficient/sample word stream
//   r_valid/r_ready/r_data : result stream out of the result FIFO
// modport master : host/DMA side (drives s_valid, s_data, r_ready)
// modport slave  : sequencer side (drives s_ready, r_valid, r_data)
// -----------------------------------------------------------------------------
interface fir_host_if
  import fir_host_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          r_valid;
  logic          r_ready;
  logic [OW-1:0] r_data;

  modport master (output s_valid, s_data, r_ready,
                  input  s_ready, r_valid, r_data);
  modport slave  (input  s_valid, s_data, r_ready,
                  output s_ready, r_valid, r_data);
endinterface

// File: rtl/fir_host_rfifo.sv
// -----------------------------------------------------------------------------
// fir_host_rfifo
// Synchronous result FIFO, OW wide, DEPTH entries (power of 2, >= 2).
// Ports: clk, rstn (async active-low), push/wdata, pop, rdata (head, 0 when
// empty), full, empty. A push while full succeeds only if a pop happens in the
// same cycle; otherwise the word is dropped. Pop while empty is ignored.
// -----------------------------------------------------------------------------
module fir_host_rfifo
  import fir_host_pkg::*;
#(
  parameter int OW    = OW_DEF,
  parameter int DEPTH = RFIFO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [OW-1:0] wdata,
  input  logic          pop,
  output logic [OW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] mem [DEPTH];
  logic          wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rd_en = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign wr_en = push && (!full || rd_en);
  assign rdata = empty ? '0 : mem[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; rdata is forced to 0 while empty,
  // so stale contents are never visible and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fir_host_seq.sv
// -----------------------------------------------------------------------------
// fir_host_seq
// Host-side sequencer for the FIR core. Loads the first NTAPS stream words as
// coefficients (cload/caddr/cin, each held COEF_HOLD cycles), then paces the
// following words into the core as samples every SAMPLE_DIV cycles, and
// buffers core results in a small FIFO with ready/valid backpressure.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   cfg_go, cfg_stop : start load (IDLE only) / abort load or end run
//   bus (slave)      : s_valid/s_ready/s_data in, r_valid/r_ready/r_data out
//   cload/caddr/cin  : coefficient write port to the core
//   start/din/valid_in : run enable and sample strobe to the core
//   dout/valid_out   : core result input
//   load_done        : high while running
//   underrun/overflow/sample_cnt : sticky status and sample count
// Macro FIR_HOST_STATUS_EN: when defined, the status outputs are implemented;
// when undefined they are tied to 0 and their logic is absent.
// -----------------------------------------------------------------------------
module fir_host_seq
  import fir_host_pkg::*;
#(
  parameter int NTAPS       = NTAPS_DEF,
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int OW          = OW_DEF,
  parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
  parameter int RFIFO_DEPTH = RFIFO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_go,
  input  logic          cfg_stop,
  fir_host_if.slave     bus,
  output logic          cload,
  output logic [AW-1:0] caddr,
  output logic [DW-1:0] cin,
  output logic          start,
  output logic [DW-1:0] din,
  output logic          valid_in,
  input  logic [OW-1:0] dout,
  input  logic          valid_out,
  output logic          load_done,
  output logic          underrun,
  output logic          overflow,
  output logic [15:0]   sample_cnt
);
  localparam int DIVW = $clog2(SAMPLE_DIV);
  localparam int HW   = (COEF_HOLD > 1) ? $clog2(COEF_HOLD) : 1;

  state_e          state_q, state_d;
  logic            cload_q, cload_d;
  logic [AW-1:0]   caddr_q, caddr_d;
  logic [DW-1:0]   cin_q, cin_d;
  logic [DW-1:0]   din_q, din_d;
  logic            valid_in_q, valid_in_d;
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            s_ready;
  logic            clr_status, smp_strobe, underrun_evt, ovf_evt;
  logic            fifo_full, fifo_empty, r_pop;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cload_d      = cload_q;
    caddr_d      = caddr_q;
    cin_d        = cin_q;
    din_d        = din_q;
    valid_in_d   = 1'b0;
    div_cnt_d    = div_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    s_ready      = 1'b0;
    clr_status   = 1'b0;
    smp_strobe   = 1'b0;
    underrun_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        cload_d   = 1'b0;
        caddr_d   = '0;
        cin_d     = '0;
        din_d     = '0;
        div_cnt_d = '0;
        if (cfg_go && !cfg_stop) begin
          state_d    = LOAD_ACC;
          clr_status = 1'b1;
        end
      end
      LOAD_ACC: begin
        s_ready = 1'b1;
        if (cfg_stop) begin
          state_d = IDLE;
          cload_d = 1'b0;
          caddr_d = '0;
        end else if (bus.s_valid) begin
          cin_d      = bus.s_data;
          cload_d    = 1'b1;
          hold_cnt_d = '0;
          state_d    = LOAD_HOLD;
        end
      end
      LOAD_HOLD: begin
        if (cfg_stop) begin
          state_d = IDLE;
          cload_d = 1'b0;
          caddr_d = '0;
        end else if (hold_cnt_q == HW'(COEF_HOLD - 1)) begin
          cload_d = 1'b0;
          caddr_d = caddr_q + AW'(1);   // wraps to 0 after the last tap
          if (caddr_q == AW'(NTAPS - 1)) begin
            state_d   = RUN;
            div_cnt_d = '0;
          end else begin
            state_d = LOAD_ACC;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      RUN: begin
        s_ready   = (div_cnt_q == '0);
        div_cnt_d = (div_cnt_q == DIVW'(SAMPLE_DIV - 1)) ? '0 : div_cnt_q + DIVW'(1);
        if (div_cnt_q == '0) begin
          if (bus.s_valid) begin
            din_d      = bus.s_data;
            valid_in_d = 1'b1;
            smp_strobe = 1'b1;
          end else begin
            underrun_evt = 1'b1;
          end
        end
        // A word accepted in the stop cycle still produces its strobe.
        if (cfg_stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cload_q    <= 1'b0;
      caddr_q    <= '0;
      cin_q      <= '0;
      din_q      <= '0;
      valid_in_q <= 1'b0;
      div_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cload_q    <= cload_d;
      caddr_q    <= caddr_d;
      cin_q      <= cin_d;
      din_q      <= din_d;
      valid_in_q <= valid_in_d;
      div_cnt_q  <= div_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign cload       = cload_q;
  assign caddr       = caddr_q;
  assign cin         = cin_q;
  assign din         = din_q;
  assign valid_in    = valid_in_q;
  assign start       = (state_q == RUN);
  assign load_done   = (state_q == RUN);

  // Result path runs in every state, independent of the sequencer.
  assign bus.r_valid = !fifo_empty;
  assign r_pop       = !fifo_empty && bus.r_ready;
  assign ovf_evt     = valid_out && fifo_full && !r_pop;

  fir_host_rfifo #(.OW(OW), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (valid_out),
    .wdata (dout),
    .pop   (r_pop),
    .rdata (bus.r_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FIR_HOST_STATUS_EN
  logic        underrun_q, underrun_d;
  logic        overflow_q, overflow_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;

  always_comb begin
    underrun_d   = underrun_q;
    overflow_d   = overflow_q;
    sample_cnt_d = sample_cnt_q;
    if (clr_status) begin
      underrun_d   = 1'b0;
      overflow_d   = 1'b0;
      sample_cnt_d = '0;
    end else begin
      if (underrun_evt) underrun_d   = 1'b1;
      if (ovf_evt)      overflow_d   = 1'b1;
      if (smp_strobe)   sample_cnt_d = sat_inc16(sample_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign underrun   = underrun_q;
  assign overflow   = overflow_q;
  assign sample_cnt = sample_cnt_q;
`else
  logic unused_status;
  assign unused_status = ^{clr_status, smp_strobe, underrun_evt, ovf_evt};
  assign underrun      = 1'b0;
  assign overflow      = 1'b0;
  assign sample_cnt    = '0;
`endif

endmodule

// File: tb/tb_fir_host_seq.sv
// -----------------------------------------------------------------------------
// tb_fir_host_seq
// Directed bench for fir_host_seq: reset values, coefficient load ramp,
// sample pacing, underrun, stop/go interplay, result FIFO (table driven),
// load abort and asynchronous reset. Status expectations follow the
// FIR_HOST_STATUS_EN macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fir_host_seq;
  import fir_host_pkg::*;

  localparam int NTAPS = 64;
  localparam int SDIV  = 200;
`ifdef FIR_HOST_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_go, cfg_stop, valid_out;
  logic [31:0] dout;
  logic        cload, start, valid_in, load_done, underrun, overflow;
  logic [5:0]  caddr;
  logic [15:0] cin, din, sample_cnt;

  fir_host_if #(.DW(16), .OW(32)) bus ();

  fir_host_seq #(.NTAPS(NTAPS), .AW(6), .DW(16), .OW(32),
                 .SAMPLE_DIV(SDIV), .RFIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .cfg_go(cfg_go), .cfg_stop(cfg_stop), .bus(bus),
    .cload(cload), .caddr(caddr), .cin(cin), .start(start), .din(din),
    .valid_in(valid_in), .dout(dout), .valid_out(valid_out),
    .load_done(load_done), .underrun(underrun), .overflow(overflow),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int t_acc, t0, last_str;

  typedef struct {
    logic        vo;
    logic [31:0] d;
    logic        rr;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_ov;
  } fvec_t;
  fvec_t fv [18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
    return STAT ? v : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max);
    int n = 0;
    while (!bus.s_ready && n < max) begin
      step();
      n++;
    end
    check("wait_ready", bus.s_ready, 1);
  endtask

  // Present one coefficient and check the first cload cycle.
  task automatic accept_coef(input int k, input logic [15:0] val);
    wait_ready(10);
    bus.s_data = val;
    t_acc = cyc;
    step();
    check("cload_1", cload, 1);
    check("caddr_1", caddr, k);
    check("cin_1", cin, val);
  endtask

  // Second hold cycle, then the cycle after the write completes.
  task automatic finish_coef(input int k, input bit last);
    step();
    check("cload_2", cload, 1);
    check("caddr_2", caddr, k);
    step();
    check("cload_off", cload, 0);
    check("caddr_next", caddr, (k + 1) % NTAPS);
    check("s_ready_next", bus.s_ready, 1);
    check("load_done", load_done, last);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_cload"}, cload, 0);
    check({tag, "_caddr"}, caddr, 0);
    check({tag, "_cin"}, cin, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_valid_in"}, valid_in, 0);
    check({tag, "_r_valid"}, bus.r_valid, 0);
    check({tag, "_r_data"}, bus.r_data, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_sample_cnt"}, sample_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Result FIFO vectors: push+pop while full, drain, then overflow.
    fv[0]  = '{1'b1, 32'd10, 1'b0, 1'b1, 32'd10, 1'b0};
    fv[1]  = '{1'b1, 32'd11, 1'b0, 1'b1, 32'd10, 1'b0};
    fv[2]  = '{1'b1, 32'd12, 1'b0, 1'b1, 32'd10, 1'b0};
    fv[3]  = '{1'b1, 32'd13, 1'b0, 1'b1, 32'd10, 1'b0};
    fv[4]  = '{1'b1, 32'd14, 1'b1, 1'b1, 32'd11, 1'b0};
    fv[5]  = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd12, 1'b0};
    fv[6]  = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd13, 1'b0};
    fv[7]  = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd14, 1'b0};
    fv[8]  = '{1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0};
    fv[9]  = '{1'b1, 32'd1,  1'b0, 1'b1, 32'd1,  1'b0};
    fv[10] = '{1'b1, 32'd2,  1'b0, 1'b1, 32'd1,  1'b0};
    fv[11] = '{1'b1, 32'd3,  1'b0, 1'b1, 32'd1,  1'b0};
    fv[12] = '{1'b1, 32'd4,  1'b0, 1'b1, 32'd1,  1'b0};
    fv[13] = '{1'b1, 32'd5,  1'b0, 1'b1, 32'd1,  1'b1};
    fv[14] = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd2,  1'b1};
    fv[15] = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd3,  1'b1};
    fv[16] = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd4,  1'b1};
    fv[17] = '{1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b1};

    rstn = 1'b0; cfg_go = 1'b0; cfg_stop = 1'b0; valid_out = 1'b0; dout = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.r_ready = 1'b0;
    #22;
    check_reset_values("rst");
    rstn = 1'b1;
    step();
    check("idle_s_ready", bus.s_ready, 0);

    // Load ramp: coefficients 0..63 with s_valid held high.
    cfg_go = 1'b1; step(); cfg_go = 1'b0;
    check("go_s_ready", bus.s_ready, 1);
    bus.s_valid = 1'b1;
    for (int k = 0; k < NTAPS; k++) begin
      accept_coef(k, 16'(k));
      if (k == 0) t0 = t_acc;
      finish_coef(k, k == NTAPS - 1);
    end
    check("load_time", cyc - t0, 3 * NTAPS);
    check("start_run", start, 1);

    // Sample pacing.
    for (int i = 0; i < 8; i++) begin
      wait_ready(SDIV + 50);
      bus.s_data = 16'h0100 + 16'(i);
      step();
      check("valid_in_on", valid_in, 1);
      check("din", din, 16'h0100 + 16'(i));
      if (i > 0) check("pace", cyc - last_str, SDIV);
      last_str = cyc;
      step();
      check("valid_in_off", valid_in, 0);
    end
    check("sample_cnt_8", sample_cnt, st(8));

    // Underrun: skip one window.
    bus.s_valid = 1'b0;
    wait_ready(SDIV + 50);
    check("underrun_pre", underrun, 0);
    step();
    check("ur_no_strobe", valid_in, 0);
    check("ur_din_hold", din, 16'h0107);
    check("underrun_set", underrun, st(1));
    bus.s_valid = 1'b1;
    wait_ready(SDIV + 50);
    bus.s_data = 16'h0200;
    step();
    check("resume_valid", valid_in, 1);
    check("resume_din", din, 16'h0200);
    check("resume_pace", cyc - last_str, 2 * SDIV);
    check("sample_cnt_9", sample_cnt, st(9));
    step();

    // Stop in RUN coinciding with an accepted sample.
    wait_ready(SDIV + 50);
    bus.s_data = 16'h0300;
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0; bus.s_valid = 1'b0;
    check("stop_valid_in", valid_in, 1);
    check("stop_din", din, 16'h0300);
    check("stop_start", start, 0);
    check("stop_load_done", load_done, 0);
    step();
    check("idle_valid_in", valid_in, 0);
    check("idle_din", din, 0);
    check("idle_s_ready2", bus.s_ready, 0);

    // go+stop together in IDLE: stop wins.
    cfg_go = 1'b1; cfg_stop = 1'b1; step(); cfg_go = 1'b0; cfg_stop = 1'b0;
    check("gostop_s_ready", bus.s_ready, 0);
    step();
    check("gostop_s_ready2", bus.s_ready, 0);
    check("gostop_cnt", sample_cnt, st(10));

    // Fresh go clears status.
    cfg_go = 1'b1; step(); cfg_go = 1'b0;
    check("go2_s_ready", bus.s_ready, 1);
    check("go2_cnt", sample_cnt, 0);
    check("go2_underrun", underrun, 0);
    check("go2_overflow", overflow, 0);

    // Result FIFO table.
    for (int i = 0; i < 18; i++) begin
      valid_out = fv[i].vo; dout = fv[i].d; bus.r_ready = fv[i].rr;
      step();
      check($sformatf("fifo%0d_rv", i), bus.r_valid, fv[i].exp_rv);
      check($sformatf("fifo%0d_rd", i), bus.r_data, fv[i].exp_rd);
      check($sformatf("fifo%0d_ov", i), overflow, st(fv[i].exp_ov));
    end
    valid_out = 1'b0; bus.r_ready = 1'b0;

    // Abort during LOAD_HOLD at caddr 10.
    bus.s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      accept_coef(k, 16'(k));
      finish_coef(k, 1'b0);
    end
    accept_coef(10, 16'd10);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0; bus.s_valid = 1'b0;
    check("abort_cload", cload, 0);
    check("abort_caddr", caddr, 0);
    check("abort_s_ready", bus.s_ready, 0);
    step();
    check("abort_idle", bus.s_ready, 0);
    check("abort_cin", cin, 0);

    // Restart and run through to RUN for the reset test.
    cfg_go = 1'b1; step(); cfg_go = 1'b0;
    bus.s_valid = 1'b1;
    accept_coef(0, 16'h0055);
    finish_coef(0, 1'b0);
    for (int k = 1; k < NTAPS; k++) begin
      accept_coef(k, 16'(k));
      finish_coef(k, k == NTAPS - 1);
    end
    wait_ready(5);
    bus.s_data = 16'h0400;
    valid_out = 1'b1; dout = 32'h77;
    step();
    valid_out = 1'b0;
    check("pre_rst_valid_in", valid_in, 1);
    check("pre_rst_r_valid", bus.r_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check_reset_values("arst");
    #2 rstn = 1'b1;
    bus.s_valid = 1'b0;
    step();
    check("post_rst_idle", bus.s_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_host_seq.md
# fir_host_seq

Host-side sequencer that drives the FIR core's coefficient-load and sample-input ports and collects its outputs. It takes one upstream ready/valid word stream and writes the first NTAPS words into CMEM via cload/caddr/cin. It then paces the remaining words into the core as samples (start/din/valid_in) at a programmable rate and buffers dout results on valid_out into a small result FIFO with ready/valid backpressure. It sits between the host/DMA stream and the core, replacing bench-driven loading.

## Interface
- NTAPS, 64, number of coefficients loaded per configuration
- AW, 6, CMEM address width (clog2 NTAPS)
- DW, 16, coefficient/sample width
- OW, 32, core output width
- SAMPLE_DIV, 200, clk cycles between sample strobes (>= 4)
- RFIFO_DEPTH, 4, result FIFO entries (power of 2)
- clk  in  1  single clock
- rstn  in  1  asynchronous, active-low reset
- cfg_go  in  1  pulse: start coefficient load (IDLE only)
- cfg_stop  in  1  pulse: abort load / end run
- s_valid, s_ready  in/out  1  upstream handshake
- s_data  in  DW  coefficient or sample word
- cload  out  1  coefficient write enable to core
- caddr  out  AW  CMEM address
- cin  out  DW  coefficient data
- start  out  1  core run enable
- din  out  DW  sample to core
- valid_in  out  1  one-cycle sample strobe
- dout  in  OW  core result
- valid_out  in  1  core result strobe
- r_valid, r_ready  out/in  1  result handshake
- r_data  out  OW  result FIFO head
- load_done  out  1  high in RUN
- underrun, overflow  out  1  sticky status (see Configuration)
- sample_cnt  out  16  samples issued since last cfg_go

## Operation
- States: IDLE, LOAD_ACC, LOAD_HOLD, RUN.
- IDLE: s_ready=0, all core outputs at reset values. cfg_go -> LOAD_ACC; clears caddr, sample_cnt, and the sticky flags.
- LOAD_ACC: s_ready=1. On s_valid&s_ready: cin<=s_data, cload<=1 -> LOAD_HOLD.
- LOAD_HOLD: s_ready=0, cin/caddr stable, cload=1 for exactly 2 cycles. Then cload<=0 and caddr increments. If the old caddr == NTAPS-1 -> RUN (caddr wraps to 0), else -> LOAD_ACC.
- RUN: start=1. div_cnt counts 0..SAMPLE_DIV-1 and wraps. s_ready=1 only when div_cnt==0.
  - Handshake at div_cnt==0: din<=s_data, valid_in=1 the next cycle for one cycle, sample_cnt+1 (saturates at 16'hFFFF).
  - No s_valid at div_cnt==0: no strobe, din holds, underrun set, div_cnt continues.
- cfg_stop: LOAD_* -> IDLE next cycle, cload<=0, caddr<=0. RUN -> IDLE next cycle, start<=0; an in-flight valid_in still completes. cfg_go while not IDLE is ignored. cfg_go and cfg_stop together in IDLE: stop wins.
- Result FIFO is active in all states. valid_out pushes dout; r_valid=!empty; r_data=head; pop on r_valid&r_ready.
  - Push while full and no pop: word dropped, overflow set.
  - Push and pop in the same cycle while full: both succeed, no overflow.

## Timing
- Reset values: s_ready=0, cload=0, caddr=0, cin=0, start=0, din=0, valid_in=0, r_valid=0, r_data=0, load_done=0, underrun=0, overflow=0, sample_cnt=0. FIFO empty, state IDLE.
- Coefficient accepted at cycle t: cload/caddr/cin valid at t+1 and t+2. Next s_ready at t+3. Full load of NTAPS words with no stalls takes 3*NTAPS cycles.
- Sample accepted at cycle t: valid_in and din valid at t+1. Next acceptance opportunity at t+SAMPLE_DIV.
- load_done rises the cycle start rises.
- Result pushed at cycle t: r_valid at t+1. Single-word throughput is 1/cycle.

## Configuration
- FIR_HOST_STATUS_EN defined: underrun, overflow and sample_cnt are implemented as specified.
- FIR_HOST_STATUS_EN undefined: the ports remain but are tied to 0, and the counter and flag logic is absent. Drop-on-full behaviour is unchanged.

## Structure
- Package fir_host_pkg holds the state enum (IDLE, LOAD_ACC, LOAD_HOLD, RUN), the COEF_HOLD=2 constant, and default width constants.
- One sub-module: fir_host_rfifo, a synchronous FIFO with OW width, RFIFO_DEPTH depth, and full/empty outputs.

## Test plan
- Load ramp: cfg_go, stream coefficients 0..63 with s_valid held high -> 64 cload bursts of 2 cycles each, caddr 0..63 with cin==caddr, load_done at cycle 192 after the first accept.
- Sample pacing: in RUN with SAMPLE_DIV=200, stream 8 samples 0x0100..0x0107 -> valid_in pulses exactly 200 cycles apart, din matches, sample_cnt=8.
- Underrun: deassert s_valid over one div_cnt==0 window -> no valid_in that period, underrun=1, din unchanged. Same check with FIR_HOST_STATUS_EN undefined -> underrun=0.
- Result FIFO: r_ready=0, five valid_out pulses with dout=1..5 -> FIFO holds 1..4, overflow=1. Then r_ready=1 -> r_data reads 1,2,3,4 and r_valid falls. Push+pop when full -> no overflow.
- Abort: cfg_stop during LOAD_HOLD at caddr=10 -> cload=0 and caddr=0 the next cycle, state IDLE. A fresh cfg_go restarts at caddr=0.
- Async reset: drop rstn during RUN mid-strobe -> all outputs take their reset values immediately without waiting for a clock edge.
